// File: rtl/dsm_decimator.sv
// Second-order CIC decimator: turns a 1-bit delta-sigma stream into signed
// DATA_WIDTH samples, one per OSR accepted bits, after two priming windows.
module dsm_decimator #(
  parameter int DATA_WIDTH = 8,
  parameter int OSR        = 64
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_bit,
  input  logic                         i_bit_valid,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_valid,
  output logic                         o_overflow
);

  localparam int L     = $clog2(OSR);
  localparam int IW    = 2 * L + 2;
  localparam int SHIFT = 2 * L - (DATA_WIDTH - 1);

  localparam logic signed [IW-1:0] MAX_Y = IW'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [IW-1:0] MIN_Y = ~MAX_Y;

  typedef enum logic [1:0] {PRIME0, PRIME1, RUN} state_t;

  state_t state, state_next;
  logic   in_run;

  logic signed [IW-1:0] i1, i2, i2_next, x;
  logic signed [IW-1:0] dec_p0, d1, d2;
  logic signed [IW-1:0] c1, c2, y;
  logic [L-1:0]         cnt;
  logic                 window_end;
  logic                 vld_p0, emit_p0;

  function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [IW-1:0] v);
    if (v > MAX_Y)      return MAX_Y[DATA_WIDTH-1:0];
    else if (v < MIN_Y) return MIN_Y[DATA_WIDTH-1:0];
    else                return v[DATA_WIDTH-1:0];
  endfunction

  function automatic logic clamps(input logic signed [IW-1:0] v);
    return (v > MAX_Y) || (v < MIN_Y);
  endfunction

  assign x          = i_bit ? {{(IW-1){1'b0}}, 1'b1} : {IW{1'b1}};
  assign i2_next    = i2 + i1;
  assign window_end = i_bit_valid && (cnt == L'(OSR - 1));

  // Stage p0: integrate at input rate; snapshot i2 at each window end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      i1      <= '0;
      i2      <= '0;
      cnt     <= '0;
      dec_p0  <= '0;
      vld_p0  <= 1'b0;
      emit_p0 <= 1'b0;
    end else begin
      vld_p0  <= window_end;
      emit_p0 <= window_end && in_run;
      if (i_bit_valid) begin
        i1  <= i1 + x;
        i2  <= i2_next;
        cnt <= cnt + 1'b1;
        if (window_end) dec_p0 <= i2_next;
      end
    end
  end

  // Priming FSM: two windows fill the comb history before output is trusted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= PRIME0;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      PRIME0:  if (window_end) state_next = PRIME1;
      PRIME1:  if (window_end) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = PRIME0;
    endcase
  end

  always_comb begin
    in_run = (state == RUN);
  end

  assign c1 = dec_p0 - d1;
  assign c2 = c1 - d2;
  assign y  = c2 >>> SHIFT;

  // Stage p1: comb, scale and saturate; history advances even while priming
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      d1         <= '0;
      d2         <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_valid <= vld_p0 && emit_p0;
      if (vld_p0) begin
        d1 <= dec_p0;
        d2 <= c1;
      end
      if (vld_p0 && emit_p0) begin
        o_data     <= saturate(y);
        o_overflow <= o_overflow | clamps(y);
      end
    end
  end

endmodule

// File: tb/tb_dsm_decimator.sv
// Scoreboard bench for dsm_decimator: the driver queues hand-computed samples
// with their due cycle, and a negedge monitor pops one per observed strobe.
module tb_dsm_decimator;
  localparam int DW  = 8;
  localparam int OSR = 64;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 bit_in = 1'b0;
  logic                 bit_valid = 1'b0;
  logic signed [DW-1:0] data;
  logic                 valid;
  logic                 overflow;

  typedef struct { longint d; longint c; } exp_t;
  exp_t q[$];
  exp_t mon_e;

  int                   checks = 0;
  int                   failures = 0;
  int                   cyc = 0;
  int                   acc = 0;
  logic signed [DW-1:0] exp_val = '0;

  dsm_decimator #(.DATA_WIDTH(DW), .OSR(OSR)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_bit       (bit_in),
    .i_bit_valid (bit_valid),
    .o_data      (data),
    .o_valid     (valid),
    .o_overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest queued sample and its cycle
  always @(negedge clk) begin
    if (valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got data %0d, expected no strobe (cycle %0d)", data, cyc);
      end else begin
        mon_e = q.pop_front();
        check("strobe_data", longint'(data), mon_e.d);
        check("strobe_cycle", longint'(cyc), mon_e.c);
      end
    end
  end

  task automatic drive(input logic v, input logic b);
    @(posedge clk);
    #1;
    bit_valid = v;
    bit_in    = b;
    if (v) begin
      acc++;
      if ((acc % OSR) == 0 && (acc / OSR) >= 3)
        q.push_back('{longint'(exp_val), longint'(cyc + 2)});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    acc = 0;
  endtask

  task automatic expect_drained(input string name);
    check(name, longint'(q.size()), 0);
    q.delete();
  endtask

  initial begin
    int guard;

    repeat (3) @(posedge clk);
    #1;
    check("reset_data", longint'(data), 0);
    check("reset_valid", longint'(valid), 0);
    check("reset_overflow", longint'(overflow), 0);
    rst_n = 1'b1;

    // All ones: clamps to +127 from the third window
    exp_val = 8'sd127;
    for (int i = 0; i < 5 * OSR; i++) drive(1'b1, 1'b1);
    idle(5);
    expect_drained("ones_drained");
    check("ones_overflow", longint'(overflow), 1);

    // All zeros: exact -128
    do_reset();
    check("rst_overflow_clear", longint'(overflow), 0);
    exp_val = -8'sd128;
    for (int i = 0; i < 5 * OSR; i++) drive(1'b1, 1'b0);
    idle(5);
    expect_drained("zeros_drained");
    check("zeros_overflow", longint'(overflow), 0);

    // Alternating 1,0: zero mean
    do_reset();
    exp_val = 8'sd0;
    for (int i = 0; i < 5 * OSR; i++) drive(1'b1, (i % 2) == 0);
    idle(5);
    expect_drained("alt_drained");

    // 1,1,1,0: mean +0.5
    do_reset();
    exp_val = 8'sd64;
    for (int i = 0; i < 5 * OSR; i++) drive(1'b1, (i % 4) != 3);
    idle(5);
    expect_drained("p1110_drained");
    check("p1110_overflow", longint'(overflow), 0);

    // Gapped valid, all ones, then a long idle stretch
    do_reset();
    exp_val = 8'sd127;
    guard = 0;
    while (acc < 4 * OSR && guard < 5000) begin
      drive($urandom_range(0, 99) < 40, 1'b1);
      guard++;
    end
    check("gap_accepted", longint'(acc), 4 * OSR);
    idle(500);
    expect_drained("gap_drained");
    check("gap_overflow", longint'(overflow), 1);

    // Reset in the middle of window 5, then all zeros
    do_reset();
    exp_val = 8'sd127;
    for (int i = 0; i < 4 * OSR + 30; i++) drive(1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("pre_rst_overflow", longint'(overflow), 1);
    check("pre_rst_data", longint'(data), 127);
    expect_drained("pre_rst_drained");
    bit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_data", longint'(data), 0);
    check("midrst_valid", longint'(valid), 0);
    check("midrst_overflow", longint'(overflow), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    acc = 0;
    exp_val = -8'sd128;
    for (int i = 0; i < 3 * OSR; i++) drive(1'b1, 1'b0);
    idle(5);
    expect_drained("post_rst_drained");
    check("post_rst_overflow", longint'(overflow), 0);
    check("post_rst_data", longint'(data), -128);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsm_decimator.md
# dsm_decimator

Second-order sinc (CIC, N=2) decimator. It recovers signed multi-bit samples from a 1-bit delta-sigma bitstream and acts as the receive-side counterpart of the stimulus generator and modulator chain. It accepts one bit per enabled clock, integrates at the input rate, decimates by OSR, and runs a two-stage comb. It scales and saturates each result into a DATA_WIDTH signed word, flagged by a one-cycle valid strobe.

## Interface
- DATA_WIDTH, 8: output word width, signed two's complement.
- OSR, 64: decimation ratio. Must be a power of two, ≥4, with 2·log2(OSR) ≥ DATA_WIDTH-1.
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_bit  in  1  bitstream sample: 1 means +1, 0 means -1.
- i_bit_valid  in  1  sample enable. The bit is accepted on a rising edge while this is high; it may stay high continuously.
- o_data  out  DATA_WIDTH  decimated signed sample. Held between strobes.
- o_valid  out  1  one-cycle strobe: o_data was updated.
- o_overflow  out  1  sticky flag: saturation has occurred since reset.

## Operation
- Constants:
  - L = log2(OSR).
  - Internal width IW = 2L+2.
  - SHIFT = 2L-(DATA_WIDTH-1).
- Integrators i1 and i2, both IW bits. On each accepted bit:
  - i1 <= i1 + x, where x = ±1 sign-extended.
  - i2 <= i2 + i1, using the pre-update i1.
  - Arithmetic is modular (wrap-around allowed). No other saturation is applied in the integrators.
- Sample counter cnt, 0..OSR-1:
  - Increments on each accepted bit.
  - On an accepted bit with cnt==OSR-1, cnt wraps to 0 and a window-end event fires.
  - The event snapshots the post-update i2 into dec.
- Comb, evaluated on the cycle after a window-end event, with history registers d1 and d2 (IW bits, reset 0):
  - c1 = dec - d1.
  - c2 = c1 - d2.
  - Then d1 <= dec and d2 <= c1. All modular arithmetic.
- Scale: y = c2 >>> SHIFT (arithmetic, floor).
- Saturate:
  - y > 2^(DATA_WIDTH-1)-1 clamps to max; y < -2^(DATA_WIDTH-1) clamps to min.
  - A clamp sets o_overflow. o_overflow is cleared only by reset.
  - Full-scale +1 input gives y = 2^(DATA_WIDTH-1), which clamps to max and sets o_overflow.
- Priming FSM: states PRIME0 → PRIME1 → RUN.
  - Each window-end event advances one state.
  - o_valid is suppressed in PRIME0 and PRIME1; comb history still updates there.
  - The first o_valid comes from the third window after reset. RUN is terminal until reset.
- i_bit_valid low: integrators, cnt and FSM hold. A comb evaluation already scheduled still completes.
- Reset (asserted at any time, including mid-window or mid-comb):
  - i1, i2, dec, d1, d2, cnt and o_data go to 0.
  - o_valid and o_overflow go to 0.
  - FSM goes to PRIME0. No partial output is produced.

## Timing
- Window-end bit accepted at edge N: integrators and dec are updated at edge N.
- o_data is registered at edge N+1. o_valid is high from N+1 to N+2.
- Latency is 2 edges from the final sample of a window to the data strobe.
- Continuous i_bit_valid gives exactly one o_valid every OSR cycles. o_valid is never high on two consecutive cycles (OSR ≥ 4).
- o_data is stable between strobes.
- A pending comb evaluation completes even if i_bit_valid drops after edge N.

## Test plan
- All-ones, continuous valid, OSR=64, DATA_WIDTH=8:
  - No o_valid for the first 128 samples.
  - First o_valid one edge after sample 192 is accepted, with o_data=127 (raw y=128, clamped).
  - o_overflow is 1; every later strobe gives 127.
- All-zeros: every strobe from the third window onward gives o_data=-128 (exact -4096>>>5, no clamp). o_overflow stays 0.
- Alternating 1,0,1,0…: every post-priming o_data=0.
- Repeating 1,1,1,0 (mean +0.5): every post-priming o_data=64 (c2=2048).
- Gapped input: i_bit_valid pseudo-random at about 40%, all-ones data.
  - Strobes occur only after each 64th accepted bit, each with o_data=127.
  - Holding i_bit_valid low for 500 cycles produces no strobes.
- Reset mid-operation: assert i_rst_n low for 1 cycle at cnt=30 of window 5.
  - All outputs go to 0 immediately; o_overflow clears.
  - With all-zeros input after release, the next strobe occurs after 192 accepted bits with o_data=-128.
